// File: rtl/flexff.sv
// Register bank of WIDTH independent JK/D/T/SR flip-flops with per-bit enable,
// parallel load, per-bit change flags, a saturating change counter and a sticky SR error flag.
module flexff #(
  parameter int unsigned       WIDTH  = 8,
  parameter int unsigned       CWIDTH = 8,
  parameter logic [WIDTH-1:0]  RSTVAL = '0
) (
  input  logic              _clock,
  input  logic              _reset,
  input  logic [1:0]        _mode,
  input  logic [WIDTH-1:0]  _J,
  input  logic [WIDTH-1:0]  _K,
  input  logic [WIDTH-1:0]  _E,
  input  logic              _load,
  input  logic [WIDTH-1:0]  _loadval,
  input  logic              _clrcount,
  output logic [WIDTH-1:0]  _Q,
  output logic [WIDTH-1:0]  _QNOT,
  output logic [WIDTH-1:0]  _return,
  output logic [WIDTH-1:0]  _changed,
  output logic [CWIDTH-1:0] _count,
  output logic              _err
);

  typedef enum logic [1:0] {
    MODE_JK = 2'b00,
    MODE_D  = 2'b01,
    MODE_T  = 2'b10,
    MODE_SR = 2'b11
  } mode_e;

  mode_e             mode;
  logic [WIDTH-1:0]  q_q, q_d;
  logic [WIDTH-1:0]  op;
  logic [WIDTH-1:0]  changed_q, changed_d;
  logic [CWIDTH-1:0] count_q, count_d;
  logic              err_q, err_d;
  logic              sr_err;

  assign mode = mode_e'(_mode);

  always_comb begin
    op     = q_q;
    sr_err = 1'b0;
    q_d    = q_q;
    unique case (mode)
      MODE_JK: op = (_J & ~q_q) | (~_K & q_q);
      MODE_D:  op = _J;
      MODE_T:  op = q_q ^ _J;
      MODE_SR: begin
        // S=R=1 holds the bit; only enabled bits may raise the error.
        op     = (q_q | (_J & ~_K)) & ~(_K & ~_J);
        sr_err = |(_E & _J & _K);
      end
    endcase

    if (_load) begin
      q_d    = _loadval;
      sr_err = 1'b0;
    end else begin
      q_d = (_E & op) | (~_E & q_q);
    end

    changed_d = q_d ^ q_q;

    count_d = count_q;
    err_d   = err_q | sr_err;
    if (_clrcount) begin
      count_d = '0;
      err_d   = 1'b0;
    end else if ((|changed_d) && (count_q != '1)) begin
      count_d = count_q + CWIDTH'(1);
    end
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      q_q       <= RSTVAL;
      changed_q <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      q_q       <= q_d;
      changed_q <= changed_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  assign _Q       = q_q;
  assign _QNOT    = ~q_q;
  assign _return  = q_q;
  assign _changed = changed_q;
  assign _count   = count_q;
  assign _err     = err_q;

endmodule

// File: tb/tb_flexff.sv
// Directed and randomised stimulus for flexff (WIDTH=4, CWIDTH=3, RSTVAL=0) with a
// scoreboard queue of expected register state filled at drive time and drained after each edge.
module tb_flexff;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [3:0] j, k, e;
  logic       load;
  logic [3:0] loadval;
  logic       clr;
  logic [3:0] q, qnot, ret, chg;
  logic [2:0] cnt;
  logic       err;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [3:0] q;
    logic [3:0] chg;
    logic [2:0] cnt;
    logic       err;
    string      tag;
  } exp_t;

  exp_t sb[$];

  // Reference state, advanced independently of the DUT.
  logic [3:0] m_q   = 4'b0000;
  logic [3:0] m_chg = 4'b0000;
  logic [2:0] m_cnt = 3'd0;
  logic       m_err = 1'b0;

  flexff #(.WIDTH(4), .CWIDTH(3), .RSTVAL(4'b0000)) dut (
    ._clock    (clk),
    ._reset    (rst),
    ._mode     (mode),
    ._J        (j),
    ._K        (k),
    ._E        (e),
    ._load     (load),
    ._loadval  (loadval),
    ._clrcount (clr),
    ._Q        (q),
    ._QNOT     (qnot),
    ._return   (ret),
    ._changed  (chg),
    ._count    (cnt),
    ._err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic model_edge();
    logic [3:0] nq;
    logic [3:0] tj, tk, te, tq;
    logic       bad;
    logic       b;
    nq  = 4'b0000;
    bad = 1'b0;
    tj = j; tk = k; te = e; tq = m_q;
    for (int i = 0; i < 4; i++) begin
      b = tq[0];
      if (te[0]) begin
        case (mode)
          2'b00: begin
            if (tj[0] && tk[0])      b = ~tq[0];
            else if (tj[0])          b = 1'b1;
            else if (tk[0])          b = 1'b0;
          end
          2'b01: b = tj[0];
          2'b10: if (tj[0]) b = ~tq[0];
          default: begin
            if (tj[0] && !tk[0])     b = 1'b1;
            else if (!tj[0] && tk[0]) b = 1'b0;
            else if (tj[0] && tk[0]) bad = 1'b1;
          end
        endcase
      end
      nq = {b, nq[3:1]};
      tj = tj >> 1; tk = tk >> 1; te = te >> 1; tq = tq >> 1;
    end
    if (load) begin
      nq  = loadval;
      bad = 1'b0;
    end
    if (rst) begin
      m_q = 4'b0000; m_chg = 4'b0000; m_cnt = 3'd0; m_err = 1'b0;
    end else begin
      m_chg = nq ^ m_q;
      m_q   = nq;
      if (clr) begin
        m_cnt = 3'd0;
        m_err = 1'b0;
      end else begin
        if (m_chg != 4'b0000 && m_cnt != 3'd7) m_cnt = m_cnt + 3'd1;
        if (bad) m_err = 1'b1;
      end
    end
  endtask

  task automatic step(input logic r, input logic [1:0] md, input logic [3:0] jj,
                      input logic [3:0] kk, input logic [3:0] ee, input logic ld,
                      input logic [3:0] lv, input logic cl, input string tag);
    exp_t x;
    rst = r; mode = md; j = jj; k = kk; e = ee; load = ld; loadval = lv; clr = cl;
    model_edge();
    x.q = m_q; x.chg = m_chg; x.cnt = m_cnt; x.err = m_err; x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_out();
    exp_t x;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: empty queue, observed output without expectation");
      return;
    end
    x = sb.pop_front();
    tests++;
    assert (q === x.q) else begin
      fails++; $error("FAIL %s Q: got %b expected %b", x.tag, q, x.q);
    end
    tests++;
    assert (qnot === ~x.q) else begin
      fails++; $error("FAIL %s QNOT: got %b expected %b", x.tag, qnot, ~x.q);
    end
    tests++;
    assert (ret === x.q) else begin
      fails++; $error("FAIL %s return: got %b expected %b", x.tag, ret, x.q);
    end
    tests++;
    assert (chg === x.chg) else begin
      fails++; $error("FAIL %s changed: got %b expected %b", x.tag, chg, x.chg);
    end
    tests++;
    assert (cnt === x.cnt) else begin
      fails++; $error("FAIL %s count: got %0d expected %0d", x.tag, cnt, x.cnt);
    end
    tests++;
    assert (err === x.err) else begin
      fails++; $error("FAIL %s err: got %b expected %b", x.tag, err, x.err);
    end
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; j = '0; k = '0; e = '0; load = 1'b0; loadval = '0; clr = 1'b0;
    #1;
    // Reset overrides a simultaneous load and SR error.
    step(1, 2'b11, 4'b1111, 4'b1111, 4'b1111, 1, 4'b0110, 0, "reset");
    tests++;
    assert (q === 4'b0000 && cnt === 3'd0) else begin
      fails++; $error("FAIL reset_const: got q=%b cnt=%0d expected q=0000 cnt=0", q, cnt);
    end

    // JK toggle three times.
    step(0, 2'b00, 4'b1111, 4'b1111, 4'b1111, 0, 4'b0000, 0, "jk_t1");
    step(0, 2'b00, 4'b1111, 4'b1111, 4'b1111, 0, 4'b0000, 0, "jk_t2");
    step(0, 2'b00, 4'b1111, 4'b1111, 4'b1111, 0, 4'b0000, 0, "jk_t3");
    tests++;
    assert (q === 4'b1111 && chg === 4'b1111 && cnt === 3'd3) else begin
      fails++; $error("FAIL jk_const: got q=%b chg=%b cnt=%0d expected 1111/1111/3", q, chg, cnt);
    end
    // JK set/clear/hold mixed across bits.
    step(0, 2'b00, 4'b0011, 4'b0101, 4'b1111, 0, 4'b0000, 0, "jk_mix");

    // Clear bank and counters, then SR checks.
    step(0, 2'b01, 4'b0000, 4'b0000, 4'b1111, 0, 4'b0000, 1, "clr_d");
    step(0, 2'b11, 4'b0101, 4'b0110, 4'b0011, 0, 4'b0000, 0, "sr_setclr");
    tests++;
    assert (q === 4'b0001 && err === 1'b0) else begin
      fails++; $error("FAIL sr_const: got q=%b err=%b expected 0001/0", q, err);
    end
    step(0, 2'b11, 4'b0011, 4'b0011, 4'b0011, 0, 4'b0000, 0, "sr_both");
    tests++;
    assert (q === 4'b0001 && err === 1'b1) else begin
      fails++; $error("FAIL sr_err_const: got q=%b err=%b expected 0001/1", q, err);
    end
    step(0, 2'b00, 4'b0000, 4'b0000, 4'b1111, 0, 4'b0000, 0, "err_sticky");
    // Error on same edge as clear is discarded; disabled S=R=1 is harmless.
    step(0, 2'b11, 4'b1111, 4'b1111, 4'b1111, 0, 4'b0000, 1, "err_clr_same");
    step(0, 2'b11, 4'b1100, 4'b1100, 4'b0011, 0, 4'b0000, 0, "sr_disabled");

    // Load beats mode; reset beats load.
    step(0, 2'b10, 4'b1111, 4'b0000, 4'b1111, 1, 4'b1010, 0, "load");
    tests++;
    assert (q === 4'b1010) else begin
      fails++; $error("FAIL load_const: got %b expected 1010", q);
    end
    step(1, 2'b10, 4'b1111, 4'b0000, 4'b1111, 1, 4'b1010, 0, "load_rst");

    // T-mode saturation then clear while toggling.
    for (int n = 0; n < 10; n++)
      step(0, 2'b10, 4'b0001, 4'b0000, 4'b1111, 0, 4'b0000, 0, "t_sat");
    tests++;
    assert (cnt === 3'd7) else begin
      fails++; $error("FAIL sat_const: got %0d expected 7", cnt);
    end
    step(0, 2'b10, 4'b0001, 4'b0000, 4'b1111, 0, 4'b0000, 1, "t_clr");
    tests++;
    assert (cnt === 3'd0 && q === 4'b0001) else begin
      fails++; $error("FAIL t_clr_const: got cnt=%0d q=%b expected 0/0001", cnt, q);
    end

    // D with partial enable.
    step(1, 2'b00, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 0, "rst2");
    step(0, 2'b01, 4'b1111, 4'b0000, 4'b1100, 0, 4'b0000, 0, "d_en1");
    step(0, 2'b01, 4'b1111, 4'b0000, 4'b1100, 0, 4'b0000, 0, "d_en2");
    tests++;
    assert (q === 4'b1100 && chg === 4'b0000 && cnt === 3'd1) else begin
      fails++; $error("FAIL d_const: got q=%b chg=%b cnt=%0d expected 1100/0000/1", q, chg, cnt);
    end

    // Random mode switching every edge.
    for (int n = 0; n < 40; n++)
      step(($urandom_range(0, 19) == 0), 2'($urandom_range(0, 3)), 4'($urandom),
           4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0), 4'($urandom),
           ($urandom_range(0, 9) == 0), "rand");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
